// File: rtl/multdiv_sequencer_pkg.sv
// Shared constants for the multiply/divide sequencer: decode fields, FSM states,
// exception codes and the rstatus register index.
package multdiv_sequencer_pkg;

    localparam logic [4:0] OPC_ALU   = 5'b00000;
    localparam logic [4:0] ALUOP_MUL = 5'b00110;
    localparam logic [4:0] ALUOP_DIV = 5'b00111;

    localparam int EXC_MUL     = 4;
    localparam int EXC_DIV     = 5;
    localparam int EXC_TIMEOUT = 6;

    localparam logic [4:0] RSTATUS_IDX = 5'd30;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_START = 2'b01,
        S_BUSY  = 2'b10,
        S_WB    = 2'b11
    } state_t;

endpackage

// File: rtl/multdiv_sequencer_timeout_counter.sv
// Counts BUSY cycles and flags the cycle in which the LIMIT-th BUSY cycle is
// reached, so the sequencer leaves BUSY after exactly LIMIT cycles.
module md_timeout_counter #(
    parameter int LIMIT = 40
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/multdiv_sequencer.sv
// Start/stall/write-back sequencer for the shared multiplier/divider.
// Optional BUSY watchdog enabled by defining MULTDIV_TIMEOUT_EN.
module multdiv_sequencer
    import multdiv_sequencer_pkg::*;
#(
    parameter logic [4:0] RSTATUS_REG    = RSTATUS_IDX,
    parameter int         MUL_EXC_CODE   = EXC_MUL,
    parameter int         DIV_EXC_CODE   = EXC_DIV,
    parameter int         TIMEOUT_CYCLES = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] q_imem,
    input  logic        data_resultRDY,
    input  logic        data_exception,
    input  logic [31:0] data_result,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic        stall,
    output logic        md_wb_en,
    output logic [4:0]  md_wb_reg,
    output logic [31:0] md_wb_data
);

    state_t      state, state_next;
    logic        dec_mul, dec_div, md_op;
    logic        is_div;
    logic [4:0]  rd;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        timeout_expired;

    assign dec_mul = (q_imem[31:27] == OPC_ALU) && (q_imem[6:2] == ALUOP_MUL);
    assign dec_div = (q_imem[31:27] == OPC_ALU) && (q_imem[6:2] == ALUOP_DIV);
    assign md_op   = dec_mul || dec_div;

`ifdef MULTDIV_TIMEOUT_EN
    md_timeout_counter #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .clear  (state == S_START),
        .enable (state == S_BUSY),
        .expired(timeout_expired)
    );
`else
    // Watchdog absent: BUSY waits for the unit indefinitely.
    assign timeout_expired = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ctrl_MULT  = 1'b0;
        ctrl_DIV   = 1'b0;
        stall      = 1'b0;
        case (state)
            S_IDLE: begin
                // Only combinational path from q_imem; forced low while in reset.
                stall = md_op && !reset;
                if (md_op) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                ctrl_MULT  = !is_div;
                ctrl_DIV   = is_div;
                stall      = 1'b1;
                state_next = S_BUSY;
            end
            S_BUSY: begin
                stall = 1'b1;
                if (data_resultRDY || timeout_expired) begin
                    state_next = S_WB;
                end
            end
            S_WB: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            is_div  <= 1'b0;
            rd      <= '0;
            wb_reg  <= '0;
            wb_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (md_op) begin
                        is_div <= dec_div;
                        rd     <= q_imem[26:22];
                    end
                end
                S_BUSY: begin
                    // A real result beats a watchdog expiry in the same cycle.
                    if (data_resultRDY) begin
                        if (data_exception) begin
                            wb_reg  <= RSTATUS_REG;
                            wb_data <= is_div ? 32'(DIV_EXC_CODE) : 32'(MUL_EXC_CODE);
                        end else begin
                            wb_reg  <= rd;
                            wb_data <= data_result;
                        end
                    end else if (timeout_expired) begin
                        wb_reg  <= RSTATUS_REG;
                        wb_data <= 32'(EXC_TIMEOUT);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign md_wb_en   = (state == S_WB) && (wb_reg != 5'd0);
    assign md_wb_reg  = (state == S_WB) ? wb_reg  : 5'd0;
    assign md_wb_data = (state == S_WB) ? wb_data : 32'd0;

endmodule
